// File: rtl/riscv_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : riscv_pkg                                                        |
// | Brief   : RV32I opcode/funct3 encodings and ALU operation decode.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package riscv_pkg;

   localparam logic [6:0] OP_ALUREG = 7'b0110011;
   localparam logic [6:0] OP_ALUIMM = 7'b0010011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   localparam logic [2:0] F3_LB   = 3'b000;
   localparam logic [2:0] F3_LH   = 3'b001;
   localparam logic [2:0] F3_LW   = 3'b010;
   localparam logic [2:0] F3_LBU  = 3'b100;
   localparam logic [2:0] F3_LHU  = 3'b101;

   localparam logic [2:0] F3_SB   = 3'b000;
   localparam logic [2:0] F3_SH   = 3'b001;
   localparam logic [2:0] F3_SW   = 3'b010;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
      ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
   } alu_op_e;

   // SUB only exists for register-register ops; immediate forms reuse bit 30 as imm.
   function automatic alu_op_e alu_decode(input logic [2:0] f3,
                                          input logic       f7b5,
                                          input logic       is_reg);
      alu_op_e op;
      case (f3)
         F3_ADD:  op = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
         F3_SLL:  op = ALU_SLL;
         F3_SLT:  op = ALU_SLT;
         F3_SLTU: op = ALU_SLTU;
         F3_XOR:  op = ALU_XOR;
         F3_SR:   op = f7b5 ? ALU_SRA : ALU_SRL;
         F3_OR:   op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

endpackage
`default_nettype wire

// File: rtl/riscv_single_cycle_alu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : riscv_alu                                                        |
// | Brief   : Combinational RV32I ALU with branch comparison flags.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_alu
   import riscv_pkg::*;
(
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [2:0]  funct3,
   input  logic        funct7b5,
   input  logic        isALUreg,
   output logic [31:0] result,
   output logic        eq,
   output logic        lt,
   output logic        ltu
);

   alu_op_e     w_op;
   logic [4:0]  w_shamt;
   logic [31:0] w_sra;

   assign w_op    = alu_decode(funct3, funct7b5, isALUreg);
   assign w_shamt = b[4:0];
   assign w_sra   = $signed(a) >>> w_shamt;

   assign eq  = (a == b);
   assign lt  = ($signed(a) < $signed(b));
   assign ltu = (a < b);

   always_comb begin
      result = 32'd0;
      case (w_op)
         ALU_ADD:  result = a + b;
         ALU_SUB:  result = a - b;
         ALU_SLL:  result = a << w_shamt;
         ALU_SLT:  result = {31'd0, lt};
         ALU_SLTU: result = {31'd0, ltu};
         ALU_XOR:  result = a ^ b;
         ALU_SRL:  result = a >> w_shamt;
         ALU_SRA:  result = w_sra;
         ALU_OR:   result = a | b;
         ALU_AND:  result = a & b;
         default:  result = 32'd0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/riscv_single_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : riscv_single_cycle                                               |
// | Brief   : Single-cycle RV32I core with internal ROM, data RAM and regfile. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module riscv_single_cycle
   import riscv_pkg::*;
#(
   parameter int    IMEM_WORDS = 256,
   parameter int    DMEM_WORDS = 256,
   parameter string IMEM_INIT  = "program.mem"
) (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] pc,
   output logic [31:0] instr,
   output logic [31:0] memWdata,
   output logic [31:0] addr,
   output logic [31:0] aluIn1,
   output logic [31:0] aluIn2,
   output logic [31:0] Simm,
   output logic [31:0] memRdata,
   output logic [4:0]  rs1Id,
   output logic [4:0]  rs2Id,
   output logic [4:0]  rdId,
   output logic [3:0]  memWMask,
   output logic        isALUreg,
   output logic        isALUimm,
   output logic        isBranch,
   output logic        isJAL,
   output logic        isJALR,
   output logic        isLUI,
   output logic        isAUIPC,
   output logic        isLoad,
   output logic        isStore,
   output logic        regWrite,
   output logic        isShamt
);

   localparam int IAW = $clog2(IMEM_WORDS);
   localparam int DAW = $clog2(DMEM_WORDS);

   logic [31:0] imem   [IMEM_WORDS];
   logic [31:0] dmem_q [DMEM_WORDS];
   logic [31:0] rf_q   [32];
   logic [31:0] pc_q, pc_d;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [31:0] i_imm, b_imm, u_imm, j_imm;
   logic [31:0] rs1_val, rs2_val;
   logic [31:0] alu_result;
   logic        alu_eq, alu_lt, alu_ltu;
   logic        take_branch;
   logic        op_valid;
   logic [31:0] pc_plus4;
   logic [31:0] load_data;
   logic [31:0] wb_data;

   assign pc     = pc_q;
   assign instr  = imem[pc_q[IAW+1:2]];
   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign rs1Id  = instr[19:15];
   assign rs2Id  = instr[24:20];
   assign rdId   = instr[11:7];

   assign isALUreg = (opcode == OP_ALUREG);
   assign isALUimm = (opcode == OP_ALUIMM);
   assign isBranch = (opcode == OP_BRANCH);
   assign isJALR   = (opcode == OP_JALR);
   assign isJAL    = (opcode == OP_JAL);
   assign isAUIPC  = (opcode == OP_AUIPC);
   assign isLUI    = (opcode == OP_LUI);
   assign isLoad   = (opcode == OP_LOAD);
   assign isStore  = (opcode == OP_STORE);
   assign isShamt  = isALUimm && ((funct3 == F3_SLL) || (funct3 == F3_SR));
   assign op_valid = isALUreg | isALUimm | isBranch | isJALR | isJAL |
                     isAUIPC | isLUI | isLoad | isStore;

   assign i_imm = {{21{instr[31]}}, instr[30:20]};
   assign Simm  = {{21{instr[31]}}, instr[30:25], instr[11:7]};
   assign b_imm = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
   assign u_imm = {instr[31:12], 12'd0};
   assign j_imm = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};

   assign rs1_val = (rs1Id == 5'd0) ? 32'd0 : rf_q[rs1Id];
   assign rs2_val = (rs2Id == 5'd0) ? 32'd0 : rf_q[rs2Id];
   assign aluIn1  = rs1_val;
   assign aluIn2  = (isALUreg || isBranch) ? rs2_val : i_imm;

   riscv_alu u_alu (
      .a        (aluIn1),
      .b        (aluIn2),
      .funct3   (funct3),
      .funct7b5 (instr[30]),
      .isALUreg (isALUreg),
      .result   (alu_result),
      .eq       (alu_eq),
      .lt       (alu_lt),
      .ltu      (alu_ltu)
   );

   always_comb begin
      take_branch = 1'b0;
      case (funct3)
         F3_BEQ:  take_branch = alu_eq;
         F3_BNE:  take_branch = !alu_eq;
         F3_BLT:  take_branch = alu_lt;
         F3_BGE:  take_branch = !alu_lt;
         F3_BLTU: take_branch = alu_ltu;
         F3_BGEU: take_branch = !alu_ltu;
         default: take_branch = 1'b0;
      endcase
   end

   assign addr     = isStore ? (rs1_val + Simm) : (rs1_val + i_imm);
   assign memRdata = dmem_q[addr[DAW+1:2]];

   always_comb begin
      load_data = memRdata;
      case (funct3)
         F3_LB, F3_LBU: begin
            case (addr[1:0])
               2'd0:    load_data = {24'd0, memRdata[7:0]};
               2'd1:    load_data = {24'd0, memRdata[15:8]};
               2'd2:    load_data = {24'd0, memRdata[23:16]};
               default: load_data = {24'd0, memRdata[31:24]};
            endcase
            if (funct3 == F3_LB) load_data[31:8] = {24{load_data[7]}};
         end
         F3_LH, F3_LHU: begin
            load_data = addr[1] ? {16'd0, memRdata[31:16]} : {16'd0, memRdata[15:0]};
            if (funct3 == F3_LH) load_data[31:16] = {16{load_data[15]}};
         end
         default: load_data = memRdata;
      endcase
   end

   always_comb begin
      memWMask = 4'b0000;
      memWdata = rs2_val;
      if (isStore) begin
         case (funct3)
            F3_SB: begin
               memWMask = 4'b0001 << addr[1:0];
               memWdata = {24'd0, rs2_val[7:0]} << {addr[1:0], 3'b000};
            end
            F3_SH: begin
               memWMask = 4'b0011 << {addr[1], 1'b0};
               memWdata = {16'd0, rs2_val[15:0]} << {addr[1], 4'b0000};
            end
            F3_SW: memWMask = 4'b1111;
            default: memWMask = 4'b0000;
         endcase
      end
   end

   assign regWrite = op_valid && !(isBranch || isStore) && (rdId != 5'd0);
   assign pc_plus4 = pc_q + 32'd4;

   always_comb begin
      wb_data = alu_result;
      if (isJAL || isJALR) wb_data = pc_plus4;
      else if (isLUI)      wb_data = u_imm;
      else if (isAUIPC)    wb_data = pc_q + u_imm;
      else if (isLoad)     wb_data = load_data;
   end

   always_comb begin
      pc_d = pc_plus4;
      if (isBranch && take_branch) pc_d = pc_q + b_imm;
      else if (isJAL)              pc_d = pc_q + j_imm;
      else if (isJALR)             pc_d = (rs1_val + i_imm) & ~32'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) pc_q <= 32'd0;
      else       pc_q <= pc_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) rf_q[i] <= 32'd0;
      end else if (regWrite) begin
         rf_q[rdId] <= wb_data;
      end
   end

   // Data RAM keeps its contents across reset; stores are suppressed while held.
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int b = 0; b < 4; b++) begin
            if (memWMask[b]) dmem_q[addr[DAW+1:2]][8*b +: 8] <= memWdata[8*b +: 8];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_riscv_single_cycle.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_riscv_single_cycle                                            |
// | Brief   : Scoreboard bench: preloads a program, checks per-cycle retire.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_riscv_single_cycle;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] pc, instr, memWdata, addr, aluIn1, aluIn2, Simm, memRdata;
   logic [4:0]  rs1Id, rs2Id, rdId;
   logic [3:0]  memWMask;
   logic        isALUreg, isALUimm, isBranch, isJAL, isJALR, isLUI, isAUIPC;
   logic        isLoad, isStore, regWrite, isShamt;

   riscv_single_cycle #(.IMEM_WORDS(256), .DMEM_WORDS(256), .IMEM_INIT("")) dut (
      .clk(clk), .reset(reset), .pc(pc), .instr(instr), .memWdata(memWdata),
      .addr(addr), .aluIn1(aluIn1), .aluIn2(aluIn2), .Simm(Simm),
      .memRdata(memRdata), .rs1Id(rs1Id), .rs2Id(rs2Id), .rdId(rdId),
      .memWMask(memWMask), .isALUreg(isALUreg), .isALUimm(isALUimm),
      .isBranch(isBranch), .isJAL(isJAL), .isJALR(isJALR), .isLUI(isLUI),
      .isAUIPC(isAUIPC), .isLoad(isLoad), .isStore(isStore),
      .regWrite(regWrite), .isShamt(isShamt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] val;
      logic [3:0]  mask;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] prog[$];
   int          n_tests = 0;
   int          n_fail  = 0;

   task automatic check32(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [31:0] imm);
      return {imm[11:0], rs1, f3, rd, op};
   endfunction

   function automatic logic [31:0] enc_r(input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] rd, input logic [4:0] rs1,
                                         input logic [4:0] rs2);
      return {f7, rs2, rs1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] enc_s(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
      return {imm[11:5], rs2, rs1, f3, imm[4:0], 7'h23};
   endfunction

   function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1,
                                         input logic [4:0] rs2, input logic [31:0] imm);
      return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'h63};
   endfunction

   function automatic logic [31:0] enc_u(input logic [6:0] op, input logic [4:0] rd,
                                         input logic [19:0] imm);
      return {imm, rd, op};
   endfunction

   function automatic logic [31:0] enc_j(input logic [4:0] rd, input logic [31:0] imm);
      return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'h6F};
   endfunction

   task automatic expect_retire(input logic [31:0] p, input logic rw, input logic [4:0] rd,
                                input logic [31:0] v, input logic [3:0] m);
      exp_t e;
      e.pc = p; e.rw = rw; e.rd = rd; e.val = v; e.mask = m;
      exp_q.push_back(e);
   endtask

   initial begin
      exp_t r;

      prog.push_back(enc_i(7'h13, 3'd0, 5'd1, 5'd0, 32'd5));           // 00 addi x1,x0,5
      prog.push_back(enc_i(7'h13, 3'd0, 5'd2, 5'd1, -32'sd3));         // 04 addi x2,x1,-3
      prog.push_back(enc_r(3'd0, 7'h00, 5'd8, 5'd1, 5'd2));            // 08 add x8,x1,x2
      prog.push_back(enc_u(7'h37, 5'd3, 20'h12345));                   // 0C lui x3
      prog.push_back(enc_u(7'h17, 5'd4, 20'h00001));                   // 10 auipc x4,1
      prog.push_back(enc_r(3'd0, 7'h20, 5'd9, 5'd1, 5'd2));            // 14 sub x9,x1,x2
      prog.push_back(enc_s(3'd2, 5'd0, 5'd1, 32'd8));                  // 18 sw x1,8(x0)
      prog.push_back(enc_s(3'd0, 5'd0, 5'd2, 32'd13));                 // 1C sb x2,13(x0)
      prog.push_back(enc_i(7'h03, 3'd2, 5'd5, 5'd0, 32'd8));           // 20 lw x5,8(x0)
      prog.push_back(enc_i(7'h03, 3'd4, 5'd6, 5'd0, 32'd13));          // 24 lbu x6,13(x0)
      prog.push_back(enc_b(3'd0, 5'd1, 5'd1, 32'd8));                  // 28 beq x1,x1,+8
      prog.push_back(enc_i(7'h13, 3'd0, 5'd10, 5'd0, 32'd1));          // 2C skipped
      prog.push_back(enc_b(3'd1, 5'd1, 5'd1, 32'd8));                  // 30 bne x1,x1,+8
      prog.push_back(enc_i(7'h13, 3'd0, 5'd0, 5'd0, 32'd9));           // 34 addi x0,x0,9
      prog.push_back(enc_i(7'h13, 3'd0, 5'd11, 5'd0, -32'sd1));        // 38 addi x11,x0,-1
      prog.push_back(enc_i(7'h13, 3'd0, 5'd0, 5'd0, 32'd0));           // 3C nop
      prog.push_back(enc_j(5'd7, 32'd12));                             // 40 jal x7,+12
      prog.push_back(enc_i(7'h13, 3'd0, 5'd10, 5'd0, 32'd2));          // 44 skipped
      prog.push_back(enc_i(7'h13, 3'd0, 5'd10, 5'd0, 32'd2));          // 48 skipped
      prog.push_back(enc_i(7'h67, 3'd0, 5'd12, 5'd0, 32'h55));         // 4C jalr x12,0x55(x0)
      prog.push_back(enc_i(7'h13, 3'd0, 5'd10, 5'd0, 32'd3));          // 50 skipped
      prog.push_back(enc_r(3'd2, 7'h00, 5'd14, 5'd11, 5'd1));          // 54 slt x14,x11,x1
      prog.push_back(enc_r(3'd3, 7'h00, 5'd15, 5'd1, 5'd11));          // 58 sltu x15,x1,x11
      prog.push_back(enc_r(3'd5, 7'h20, 5'd16, 5'd11, 5'd1));          // 5C sra x16,x11,x1
      prog.push_back(enc_j(5'd0, 32'd0));                              // 60 jal x0,0
      for (int i = 0; i < 256; i++) dut.imem[i] = (i < prog.size()) ? prog[i] : 32'd0;

      expect_retire(32'h00, 1'b1, 5'd1,  32'd5,        4'h0);
      expect_retire(32'h04, 1'b1, 5'd2,  32'd2,        4'h0);
      expect_retire(32'h08, 1'b1, 5'd8,  32'd7,        4'h0);
      expect_retire(32'h0C, 1'b1, 5'd3,  32'h12345000, 4'h0);
      expect_retire(32'h10, 1'b1, 5'd4,  32'h00001010, 4'h0);
      expect_retire(32'h14, 1'b1, 5'd9,  32'd3,        4'h0);
      expect_retire(32'h18, 1'b0, 5'd0,  32'd0,        4'hF);
      expect_retire(32'h1C, 1'b0, 5'd0,  32'd0,        4'h2);
      expect_retire(32'h20, 1'b1, 5'd5,  32'd5,        4'h0);
      expect_retire(32'h24, 1'b1, 5'd6,  32'd2,        4'h0);
      expect_retire(32'h28, 1'b0, 5'd0,  32'd0,        4'h0);
      expect_retire(32'h30, 1'b0, 5'd0,  32'd0,        4'h0);
      expect_retire(32'h34, 1'b0, 5'd0,  32'd0,        4'h0);
      expect_retire(32'h38, 1'b1, 5'd11, 32'hFFFFFFFF, 4'h0);
      expect_retire(32'h3C, 1'b0, 5'd0,  32'd0,        4'h0);
      expect_retire(32'h40, 1'b1, 5'd7,  32'h44,       4'h0);
      expect_retire(32'h4C, 1'b1, 5'd12, 32'h50,       4'h0);
      expect_retire(32'h54, 1'b1, 5'd14, 32'd1,        4'h0);
      expect_retire(32'h58, 1'b1, 5'd15, 32'd1,        4'h0);
      expect_retire(32'h5C, 1'b1, 5'd16, 32'hFFFFFFFF, 4'h0);
      expect_retire(32'h60, 1'b0, 5'd0,  32'd0,        4'h0);
      expect_retire(32'h60, 1'b0, 5'd0,  32'd0,        4'h0);

      #10;
      check32("rst_pc",       pc,                 32'd0);
      check32("rst_instr",    instr,              prog[0]);
      check32("rst_regWrite", {31'd0, regWrite},  32'd1);
      check32("rst_x1",       dut.rf_q[1],        32'd0);
      #7 reset = 1'b0;

      while (exp_q.size() > 0) begin
         r = exp_q.pop_front();
         @(negedge clk);
         check32("pc",       pc,                r.pc);
         check32("regWrite", {31'd0, regWrite}, {31'd0, r.rw});
         check32("memWMask", {28'd0, memWMask}, {28'd0, r.mask});
         if (r.rw) check32("rdId", {27'd0, rdId}, {27'd0, r.rd});
         case (r.pc)
            32'h00: begin
               check32("isALUimm", {31'd0, isALUimm}, 32'd1);
               check32("aluIn2_addi", aluIn2, 32'd5);
            end
            32'h04: begin
               check32("aluIn1_addi", aluIn1, 32'd5);
               check32("aluIn2_neg",  aluIn2, 32'hFFFFFFFD);
               check32("Simm_addi",   Simm,   32'hFFFFFFE2);
            end
            32'h08: begin
               check32("isALUreg", {31'd0, isALUreg}, 32'd1);
               check32("rs1Id", {27'd0, rs1Id}, 32'd1);
               check32("rs2Id", {27'd0, rs2Id}, 32'd2);
            end
            32'h10: check32("isAUIPC", {31'd0, isAUIPC}, 32'd1);
            32'h18: begin
               check32("isStore", {31'd0, isStore}, 32'd1);
               check32("sw_addr", addr, 32'd8);
               check32("sw_Simm", Simm, 32'd8);
               check32("sw_wdata", memWdata, 32'd5);
            end
            32'h1C: begin
               check32("sb_addr", addr, 32'd13);
               check32("sb_wdata", memWdata, 32'h00000200);
            end
            32'h20: begin
               check32("isLoad", {31'd0, isLoad}, 32'd1);
               check32("lw_rdata", memRdata, 32'd5);
            end
            32'h28: check32("isBranch", {31'd0, isBranch}, 32'd1);
            32'h40: check32("isJAL", {31'd0, isJAL}, 32'd1);
            32'h4C: check32("isJALR", {31'd0, isJALR}, 32'd1);
            default: ;
         endcase
         @(posedge clk);
         #1;
         if (r.rw) check32($sformatf("x%0d", r.rd), dut.rf_q[r.rd], r.val);
         if (r.pc == 32'h34) check32("x0_stays_0", dut.rf_q[0], 32'd0);
      end

      check32("x10_skipped", dut.rf_q[10], 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
